// File: rtl/chip_tester_pkg.sv
`default_nettype none
// ============================================================================
// chip_tester_pkg : shared state encoding, default sizes, saturating increment
// Rev 1.0
// ============================================================================
package chip_tester_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } tester_state_e;

  localparam int c_def_pin_count     = 16;
  localparam int c_def_settle_cycles = 8;
  localparam int c_def_idx_w         = 8;
  localparam int c_def_err_w         = 8;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chip_pin_sync.sv
`default_nettype none
// ============================================================================
// chip_pin_sync : WIDTH-bit two-flop synchroniser, optional falling-edge detect
// Rev 1.0
// ============================================================================
module chip_pin_sync #(
  parameter int WIDTH   = 1,
  parameter bit FALL_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
    end
  end

  assign sync_out = r_sync;

  generate
    if (FALL_EN) begin : g_fall
      // Cleared history means a line held low through reset never reads as a fresh press.
      logic [WIDTH-1:0] r_prev;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prev <= '0;
        end else begin
          r_prev <= r_sync;
        end
      end
      assign fall = r_prev & ~r_sync;
    end else begin : g_no_fall
      assign fall = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/chip_vector_tester.sv
`default_nettype none
// ============================================================================
// chip_vector_tester : streams drive/expect vectors into a DIP socket and scores them
// Optional: CHIP_TESTER_STOP_ON_FAIL_EN ends the test at the first failing vector
// Rev 1.0
// ============================================================================
module chip_vector_tester
  import chip_tester_pkg::*;
#(
  parameter int PIN_COUNT     = c_def_pin_count,
  parameter int SETTLE_CYCLES = c_def_settle_cycles,
  parameter int IDX_W         = c_def_idx_w,
  parameter int ERR_W         = c_def_err_w
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [PIN_COUNT-1:0] vec_drive,
  input  logic [PIN_COUNT-1:0] vec_oe,
  input  logic [PIN_COUNT-1:0] vec_expect,
  input  logic [PIN_COUNT-1:0] vec_mask,
  input  logic                 vec_last,
  inout  wire  [PIN_COUNT-1:0] pin,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [PIN_COUNT-1:0] fail_pins
);

  localparam int                 c_cnt_w       = $clog2(SETTLE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES - 1);

  tester_state_e        r_state;
  tester_state_e        w_next;
  logic [PIN_COUNT-1:0] r_drive;
  logic [PIN_COUNT-1:0] r_oe;
  logic [PIN_COUNT-1:0] r_expect;
  logic [PIN_COUNT-1:0] r_mask;
  logic                 r_last;
  logic [PIN_COUNT-1:0] r_samp;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [ERR_W-1:0]     r_err;
  logic [IDX_W-1:0]     r_ffi;
  logic [PIN_COUNT-1:0] r_fpins;

  logic [PIN_COUNT-1:0] w_pin_en;
  logic [PIN_COUNT-1:0] w_pin_sync;
  logic [PIN_COUNT-1:0] w_pin_fall_unused;
  logic                 w_run_sync_unused;
  logic                 w_start;
  logic [PIN_COUNT-1:0] w_mism;
  logic                 w_stop;

  chip_pin_sync #(.WIDTH(1), .FALL_EN(1'b1)) u_run_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (run),
    .sync_out (w_run_sync_unused),
    .fall     (w_start)
  );

  chip_pin_sync #(.WIDTH(PIN_COUNT), .FALL_EN(1'b0)) u_pin_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pin),
    .sync_out (w_pin_sync),
    .fall     (w_pin_fall_unused)
  );

  generate
    for (genvar gi = 0; gi < PIN_COUNT; gi++) begin : g_pin_drv
      assign pin[gi] = w_pin_en[gi] ? r_drive[gi] : 1'bz;
    end
  endgenerate

  // Driven pins are the tester's own levels, so they never count as chip failures.
  assign w_mism = (r_samp ^ r_expect) & r_mask & ~r_oe;

`ifdef CHIP_TESTER_STOP_ON_FAIL_EN
  assign w_stop = |w_mism;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (w_start)          w_next = FETCH;
      FETCH:      if (vec_valid)        w_next = SETTLE;
      SETTLE:     if (r_cnt == '0)      w_next = SAMPLE;
      SAMPLE:                           w_next = CHECK;
      CHECK:      w_next = (r_last || w_stop) ? DONE : FETCH;
      default:                          w_next = IDLE;
    endcase
  end

  // Pins hold their last drive through FETCH so the chip sees no glitch between vectors.
  always_comb begin
    vec_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    w_pin_en  = '0;
    case (r_state)
      FETCH: begin
        vec_ready = 1'b1;
        busy      = 1'b1;
        w_pin_en  = r_oe;
      end
      SETTLE, SAMPLE, CHECK: begin
        busy     = 1'b1;
        w_pin_en = r_oe;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign pass           = done && (r_err == '0);
  assign err_count      = r_err;
  assign first_fail_idx = r_ffi;
  assign fail_pins      = r_fpins;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drive  <= '0;
      r_oe     <= '0;
      r_expect <= '0;
      r_mask   <= '0;
      r_last   <= 1'b0;
      r_samp   <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_err    <= '0;
      r_ffi    <= '0;
      r_fpins  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_drive <= '0;
            r_oe    <= '0;
            r_idx   <= '0;
            r_err   <= '0;
            r_ffi   <= '0;
            r_fpins <= '0;
          end
        end
        FETCH: begin
          if (vec_valid) begin
            r_drive  <= vec_drive;
            r_oe     <= vec_oe;
            r_expect <= vec_expect;
            r_mask   <= vec_mask;
            r_last   <= vec_last;
            r_cnt    <= c_settle_load;
          end
        end
        SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - c_cnt_w'(1);
        end
        SAMPLE: r_samp <= w_pin_sync;
        CHECK: begin
          if (w_mism != '0) begin
            r_err <= ERR_W'(sat_inc(32'(r_err), ERR_W));
            // A zero error count means no failure has been seen since start.
            if (r_err == '0) begin
              r_ffi   <= r_idx;
              r_fpins <= w_mism;
            end
          end
          r_idx <= IDX_W'(sat_inc(32'(r_idx), IDX_W));
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chip_vector_tester.sv
`default_nettype none
// tb_chip_vector_tester : table-driven NAND scenarios, hand-built corner sequences and
// randomized vector streams scored against a behavioural model of the test rules.
module tb_chip_vector_tester;

  localparam int PC = 14;
  localparam int SC = 8;
  localparam int IW = 8;
  localparam int EW = 8;
  localparam int SAT_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b1;
  logic          vec_valid = 1'b0;
  logic          vec_last = 1'b0;
  logic [PC-1:0] vec_drive = '0;
  logic [PC-1:0] vec_oe = '0;
  logic [PC-1:0] vec_expect = '0;
  logic [PC-1:0] vec_mask = '0;
  wire  [PC-1:0] pin;
  logic          vec_ready, busy, done, pass;
  logic [EW-1:0] err_count;
  logic [IW-1:0] first_fail_idx;
  logic [PC-1:0] fail_pins;

  always #5 clk = ~clk;

  chip_vector_tester #(.PIN_COUNT(PC), .SETTLE_CYCLES(SC), .IDX_W(IW), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_drive(vec_drive), .vec_oe(vec_oe), .vec_expect(vec_expect), .vec_mask(vec_mask),
    .vec_last(vec_last), .pin(pin),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx), .fail_pins(fail_pins)
  );

  // Chip in the socket: 0 = empty, 1 = good 7400 gate A, 2 = output stuck high, 3 = scripted response
  logic [1:0]    mode = 2'd0;
  logic [PC-1:0] resp = '0;
  logic [PC-1:0] resp_oe = '0;
  logic [1:0]    r_ab = 2'b00;
  logic [PC-1:0] chip_en, chip_val;

  always @(posedge clk) r_ab <= pin[1:0];

  always_comb begin
    chip_en  = '0;
    chip_val = '0;
    case (mode)
      2'd1: begin chip_en[2] = 1'b1; chip_val[2] = ~(r_ab[0] & r_ab[1]); end
      2'd2: begin chip_en[2] = 1'b1; chip_val[2] = 1'b1; end
      2'd3: begin chip_en = resp_oe; chip_val = resp; end
      default: ;
    endcase
  end

  for (genvar g = 0; g < PC; g++) begin : g_chip
    assign pin[g] = chip_en[g] ? chip_val[g] : 1'bz;
  end

  typedef struct {
    logic [PC-1:0] drive;
    logic [PC-1:0] oe;
    logic [PC-1:0] exp_v;
    logic [PC-1:0] mask;
    logic [PC-1:0] resp;
    logic          last;
  } vec_t;

  typedef struct { logic a; logic b; logic y; } nand_row_t;
  typedef struct {
    logic [1:0]    mode;
    int            exp_err;
    int            exp_ffi;
    logic [PC-1:0] exp_fp;
    logic          exp_pass;
  } scen_t;

  vec_t vq[$];
  int   accepted;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [PC-1:0] d, input logic [PC-1:0] oe,
                              input logic [PC-1:0] e, input logic [PC-1:0] m,
                              input logic [PC-1:0] r, input logic l);
    vec_t v;
    v.drive = d; v.oe = oe; v.exp_v = e; v.mask = m; v.resp = r; v.last = l;
    return v;
  endfunction

  // Pins the chip answers on, that are checked, and whose answer differs from expectation.
  function automatic logic [PC-1:0] fail_bits(input vec_t v);
    logic [PC-1:0] m;
    m = '0;
    for (int p = 0; p < PC; p++)
      if (!v.oe[p] && v.mask[p] && (v.resp[p] != v.exp_v[p])) m[p] = 1'b1;
    return m;
  endfunction

  task automatic start_test();
    int cnt;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    run = 1'b1;
    cnt = 0;
    while (!busy && cnt < 20) begin @(negedge clk); cnt++; end
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic feed(input int hold_before);
    int cnt;
    accepted = 0;
    for (int i = 0; i < vq.size(); i++) begin
      if (done) break;
      if (i == hold_before && i > 0) begin
        vec_valid = 1'b0;
        cnt = 0;
        while (!vec_ready && cnt < 100) begin @(negedge clk); cnt++; end
        repeat (20) @(negedge clk);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_ready", 32'(vec_ready), 32'd1);
        chk("hold_pins", 32'(pin & vq[i-1].oe), 32'(vq[i-1].drive & vq[i-1].oe));
      end
      vec_drive = vq[i].drive; vec_oe = vq[i].oe; vec_expect = vq[i].exp_v;
      vec_mask = vq[i].mask; vec_last = vq[i].last; vec_valid = 1'b1;
      cnt = 0;
      while (!vec_ready && !done && cnt < 100) begin @(negedge clk); cnt++; end
      if (!vec_ready) break;
      @(posedge clk);
      accepted++;
      @(negedge clk);
      if (mode == 2'd3) begin resp = vq[i].resp; resp_oe = ~vq[i].oe; end
    end
    vec_valid = 1'b0;
  endtask

  task automatic run_check(input string name, input int exp_err, input int exp_ffi,
                           input logic [PC-1:0] exp_fp, input logic exp_pass,
                           input int exp_acc, input int hold);
    int cnt;
    start_test();
    feed(hold);
    cnt = 0;
    while (!done && cnt < 200) begin @(negedge clk); cnt++; end
    chk($sformatf("%s_done", name), 32'(done), 32'd1);
    chk($sformatf("%s_busy", name), 32'(busy), 32'd0);
    chk($sformatf("%s_err", name), 32'(err_count), 32'(exp_err));
    chk($sformatf("%s_ffi", name), 32'(first_fail_idx), 32'(exp_ffi));
    chk($sformatf("%s_fpins", name), 32'(fail_pins), 32'(exp_fp));
    chk($sformatf("%s_pass", name), 32'(pass), 32'(exp_pass));
    chk($sformatf("%s_accepted", name), 32'(accepted), 32'(exp_acc));
  endtask

  task automatic model_run(input string name, input int hold);
    int            errs, ffi, acc, idx;
    logic [PC-1:0] fp, m;
    logic          stop;
    errs = 0; ffi = 0; acc = 0; idx = 0; fp = '0;
    foreach (vq[i]) begin
      acc++;
      m = fail_bits(vq[i]);
      if (m != '0) begin
        if (errs == 0) begin ffi = idx; fp = m; end
        if (errs < SAT_MAX) errs++;
      end
      if (idx < SAT_MAX) idx++;
      stop = vq[i].last;
`ifdef CHIP_TESTER_STOP_ON_FAIL_EN
      if (m != '0) stop = 1'b1;
`endif
      if (stop) break;
    end
    run_check(name, errs, ffi, fp, (errs == 0), acc, hold);
  endtask

  nand_row_t nt[4];
  scen_t     sc[2];

  initial begin
    nt[0] = '{1'b0, 1'b0, 1'b1};
    nt[1] = '{1'b0, 1'b1, 1'b1};
    nt[2] = '{1'b1, 1'b0, 1'b1};
    nt[3] = '{1'b1, 1'b1, 1'b0};
    sc[0] = '{2'd1, 0, 0, 14'b00000000000000, 1'b1};
    sc[1] = '{2'd2, 1, 3, 14'b00000000000100, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_ready", 32'(vec_ready), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_ffi", 32'(first_fail_idx), 32'd0);
    chk("rst_fpins", 32'(fail_pins), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // NAND gate A: pins 1,2 driven, pin 3 compared
    for (int s = 0; s < 2; s++) begin
      mode = sc[s].mode;
      vq.delete();
      for (int k = 0; k < 4; k++)
        vq.push_back(mk({12'b0, nt[k].b, nt[k].a}, 14'b11, {11'b0, nt[k].y, 2'b0},
                        14'b100, '0, (k == 3)));
      run_check($sformatf("nand%0d", s), sc[s].exp_err, sc[s].exp_ffi, sc[s].exp_fp,
                sc[s].exp_pass, 4, -1);
    end

    mode = 2'd3;
    // Upstream stalls between vectors: pins must keep the first vector's drive
    vq.delete();
    vq.push_back(mk(14'h00A5, 14'h00FF, '0, '0, '0, 1'b0));
    vq.push_back(mk(14'h005A, 14'h00FF, 14'h2A00, 14'h3F00, 14'h2A00, 1'b1));
    model_run("hold", 1);

    // Error count and index saturation
    vq.delete();
    for (int k = 0; k < 300; k++) vq.push_back(mk('0, '0, '0, 14'h1, 14'h1, (k == 299)));
    model_run("allfail", -1);
    vq.delete();
    for (int k = 0; k < 300; k++)
      vq.push_back(mk('0, '0, '0, 14'h1, (k == 299) ? 14'h1 : 14'h0, (k == 299)));
    model_run("lastfail", -1);

    // Failure in the middle of a five-vector stream
    vq.delete();
    for (int k = 0; k < 5; k++)
      vq.push_back(mk('0, '0, '0, 14'h1, (k == 2) ? 14'h1 : 14'h0, (k == 4)));
    model_run("midfail", -1);

    // An all-zero mask vector passes whatever the chip answers
    vq.delete();
    vq.push_back(mk('0, '0, 14'h3FFF, '0, '0, 1'b1));
    model_run("nomask", -1);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 10);
      vq.delete();
      for (int k = 0; k < n; k++) begin
        vec_t v;
        v.drive = 14'($urandom); v.oe = 14'($urandom); v.mask = 14'($urandom);
        v.resp = 14'($urandom);
        v.exp_v = ($urandom_range(0, 2) != 0) ? v.resp : 14'($urandom);
        v.last = (k == n - 1);
        vq.push_back(v);
      end
      model_run($sformatf("rand%0d", r), -1);
    end

    // Asynchronous reset while a vector is settling
    mode = 2'd0;
    start_test();
    vec_drive = 14'h00FF; vec_oe = 14'h00FF; vec_expect = '0; vec_mask = '0;
    vec_last = 1'b1; vec_valid = 1'b1;
    begin
      int cnt;
      cnt = 0;
      while (!vec_ready && cnt < 50) begin @(negedge clk); cnt++; end
    end
    @(posedge clk);
    @(negedge clk);
    vec_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("settle_drive", 32'(pin[7:0] === 8'hFF), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_float", 32'(pin[7:0] === 8'hFF), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_ready", 32'(vec_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mode = 2'd3;
    vq.delete();
    vq.push_back(mk(14'h0003, 14'h0003, 14'h0100, 14'h0300, 14'h0200, 1'b1));
    model_run("after_rst", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/chip_vector_tester.md
Name: chip_vector_tester

Overview:
- Parametrised successor to the fixed 14-pin chip checker: applies a stream of test vectors to a DIP socket of PIN_COUNT pins and samples the chip's outputs.
- Per pin, each vector selects drive-or-float, gives the drive value, the expected value and a compare mask.
- Accumulates mismatches and reports pass/fail, error count, first failing vector and its failing pins to the HEX/LED display logic.
- Vectors arrive from an upstream part-library ROM sequencer over a valid/ready handshake.

Parameters:
- PIN_COUNT, 16, socket pins (14 or 16 used; any 2..32 legal).
- SETTLE_CYCLES, 8, cycles from drive update to sample, including 2-flop sync latency; minimum 3.
- IDX_W, 8, width of vector index; index saturates at 2^IDX_W-1.
- ERR_W, 8, width of error counter; saturates at all-ones.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous active-low reset.
- Run  in  1  active-low start pushbutton, asynchronous; start on synchronised falling edge.
- vec_valid  in  1  upstream vector available.
- vec_ready  out  1  tester accepts vector this cycle.
- vec_drive  in  PIN_COUNT  values driven on pins.
- vec_oe  in  PIN_COUNT  1 = tester drives pin, 0 = high-Z (chip output/power pin).
- vec_expect  in  PIN_COUNT  expected pin levels.
- vec_mask  in  PIN_COUNT  1 = compare this pin.
- vec_last  in  1  final vector of test.
- Pin  inout  PIN_COUNT  socket pins.
- busy  out  1  test in progress.
- done  out  1  test complete, results valid.
- pass  out  1  done and zero errors.
- err_count  out  ERR_W  mismatching vectors (not pins).
- first_fail_idx  out  IDX_W  index of first failing vector.
- fail_pins  out  PIN_COUNT  mismatch bits of first failing vector.

Behaviour:
- Reset (async, active-low) does the following:
  - state = IDLE.
  - All outputs 0; Pin all high-Z immediately.
  - Internal output-enable and drive registers cleared.
  - Counters and index cleared.
  - Applies mid-operation as well; vec_ready drops with no handshake completion.
- Run passes through a 2-flop synchroniser plus edge detect. A start is one cycle on the 1->0 transition. Starts are ignored outside IDLE/DONE.
- IDLE/DONE + start -> FETCH. On entry, clear err_count, first_fail_idx, fail_pins, index, done and pass.
- FETCH:
  - vec_ready=1.
  - When vec_valid&&vec_ready, capture all vector fields, go to SETTLE.
  - Waits indefinitely while vec_valid=0.
- SETTLE:
  - Pin[i] = oe_q[i] ? drive_q[i] : Z from the first SETTLE cycle.
  - Load counter SETTLE_CYCLES-1, decrement to 0, then SAMPLE.
- SAMPLE (1 cycle): latch synchronised pin levels into samp_q.
- CHECK (1 cycle):
  - mism = (samp_q ^ expect_q) & mask_q & ~oe_q; driven pins are never compared.
  - If mism != 0: err_count += 1 (saturating).
  - If this is the first failure since start, record first_fail_idx = index and fail_pins = mism.
  - index += 1 (saturating).
  - If last_q -> DONE, else -> FETCH.
- Pins keep their driven values through FETCH between vectors (no glitch to Z). Pins float only in IDLE, DONE and reset.
- DONE: done=1, pass = (err_count==0), busy=0; results hold until the next start.
- busy=1 in FETCH, SETTLE, SAMPLE, CHECK.
- Per-vector throughput: SETTLE_CYCLES + 3 cycles when vec_valid is held high.
- vec_last with an all-zero mask counts as a passing vector.

Optional Feature:
- CHIP_TESTER_STOP_ON_FAIL_EN defined: in CHECK, any nonzero mism goes directly to DONE, regardless of vec_last. The upstream stream is left unconsumed; the upstream sequencer resets its pointer on start.
- Undefined: all vectors run to vec_last, and err_count reports the total.

Decomposition:
- Shared package chip_tester_pkg holds:
  - state enum tester_state_e {IDLE, FETCH, SETTLE, SAMPLE, CHECK, DONE};
  - default parameter constants;
  - helper function for saturating increment.
- One sub-module, chip_pin_sync: parametrised-width 2-flop synchroniser, instantiated for Pin (PIN_COUNT) and Run (1), plus Run falling-edge detect.

Test Plan:
- Reset low mid-SETTLE with oe=16'h00FF -> Pin all Z in the same cycle, busy=0, done=0, vec_ready=0.
- PIN_COUNT=14, bench NAND model (7400 gate A on pins 1,2->3); 4 vectors, inputs 00/01/10/11, expect pin3 = 1,1,1,0, mask pin3 only -> done=1, pass=1, err_count=0.
- Same run with a faulty model (pin3 stuck at 1) -> err_count=1, first_fail_idx=3, fail_pins=14'b00000000000100, pass=0.
- vec_valid withheld 20 cycles during FETCH -> state holds, pins keep previous drive, busy=1.
- 300 failing vectors with IDX_W=8, ERR_W=8 -> err_count=255, index saturated, first_fail_idx=0.
- CHIP_TESTER_STOP_ON_FAIL_EN defined, failure at vector 2 of 5 -> done asserted after vector 2 CHECK, vectors 3-4 never accepted, err_count=1.
